// File: rtl/vending_machine_ctrl_pkg.sv
// Shared types and helpers for the vending controller.
// Credit state is encoded as credit/5 so coin values add directly to the state.
package vending_pkg;

    typedef enum logic [2:0] {
        S0  = 3'd0,
        S5  = 3'd1,
        S10 = 3'd2,
        S15 = 3'd3,
        S20 = 3'd4,
        S25 = 3'd5,
        S30 = 3'd6,
        S35 = 3'd7
    } state_t;

    localparam int PRICE_STATES = 6;
    localparam int COIN_W       = 3;
    localparam logic [COIN_W-1:0] NICKEL_UNITS = 3'd1;
    localparam logic [COIN_W-1:0] DIME_UNITS   = 3'd2;

    // Dime has priority over a simultaneous nickel; sale states always drain to S0.
    function automatic state_t next_credit(state_t cur, logic nickel, logic dime);
        logic [COIN_W-1:0] units;
        state_t            nxt;
        units = cur;
        nxt   = cur;
        if (int'(units) >= PRICE_STATES) begin
            nxt = S0;
        end else if (dime) begin
            nxt = state_t'(units + DIME_UNITS);
        end else if (nickel) begin
            nxt = state_t'(units + NICKEL_UNITS);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vending_machine_ctrl_if.sv
// Board-side button and LED signals of the vending controller.
interface vending_machine_ctrl_if;
    logic nb;
    logic db;
    logic s;
    logic r;

    modport slave  (input  nb, input  db, output s, output r);
    modport master (output nb, output db, input  s, input  r);
endinterface

// File: rtl/vending_machine_ctrl_coin_debouncer.sv
// Synchronizes one raw button, debounces it on the tick enable and emits a
// single-clock coin pulse coincident with the tick that raises the level.
module coin_debouncer #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic coin_o
);
    localparam int CW = $clog2(DEB_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          flip;

    assign differ = sync_q[1] ^ level_q;
    // The level flips on the DEB_SAMPLES-th consecutive differing tick.
    assign flip   = tick_i && differ && (cnt_q == CNT_LAST);
    assign coin_o = flip && sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (tick_i) begin
                if (!differ) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vending_machine_ctrl.sv
// Vending controller: tick generator, two coin debouncers and the credit FSM
// with registered sell / return-change outputs.
module vending_machine_ctrl
    import vending_pkg::*;
#(
    parameter int DIV_COUNT   = 100000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    vending_machine_ctrl_if.slave  bus
);
    localparam int TW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV_COUNT - 1);

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic [1:0]    btn;
    logic [1:0]    coin;
    state_t        state_q;
    state_t        state_d;
    logic          s_q;
    logic          r_q;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Index 0 is the nickel button, index 1 the dime button.
    assign btn = {bus.db, bus.nb};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        coin_debouncer #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .tick_i(tick),
            .btn_i (btn[gi]),
            .coin_o(coin[gi])
        );
    end

    assign state_d = tick ? next_credit(state_q, coin[0], coin[1]) : state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= (state_q == S30) || (state_q == S35);
            r_q     <= (state_q == S35);
        end
    end

    assign bus.s = s_q;
    assign bus.r = r_q;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Directed bench for vending_machine_ctrl with a sale scoreboard checked by a
// separate monitor on the sell/return outputs.
module tb_vending_machine_ctrl;
    localparam int DIV_COUNT   = 2;
    localparam int DEB_SAMPLES = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   exp_q[$];

    vending_machine_ctrl_if bus ();

    vending_machine_ctrl #(
        .DIV_COUNT  (DIV_COUNT),
        .DEB_SAMPLES(DEB_SAMPLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic press(input bit n, input bit d, input int hold);
        @(negedge clk);
        bus.nb = n;
        bus.db = d;
        repeat (hold) @(negedge clk);
        bus.nb = 1'b0;
        bus.db = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic press_chk(input string name, input bit n, input bit d, input int exp_state);
        press(n, d, 8);
        check(name, int'(dut.state_q), exp_state);
    endtask

    // Monitor: one scoreboard entry per sale, checking r and pulse length.
    bit s_prev;
    bit in_pulse;
    int run_len;
    always @(negedge clk) begin
        if (!rst) begin
            s_prev   = 1'b0;
            in_pulse = 1'b0;
            run_len  = 0;
        end else begin
            if (bus.r) check("r_implies_s", int'(bus.s), 1);
            if (bus.s && !s_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sale: got s=1 r=%0d expected no sale", bus.r);
                end else begin
                    check("sale_r", int'(bus.r), int'(exp_q.pop_front()));
                end
                in_pulse = 1'b1;
                run_len  = 1;
            end else if (bus.s) begin
                run_len++;
            end else if (s_prev && in_pulse) begin
                check("sale_len", run_len, DIV_COUNT);
                in_pulse = 1'b0;
            end
            s_prev = bus.s;
        end
    end

    initial begin
        bit found;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        bus.nb  = 1'b0;
        bus.db  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s", int'(bus.s), 0);
        check("rst_r", int'(bus.r), 0);
        check("rst_state", int'(dut.state_q), 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_s", int'(bus.s), 0);
        check("idle_r", int'(bus.r), 0);
        check("idle_state", int'(dut.state_q), 0);

        // 5 + 10 + 10 + 10 = 35: sale with change.
        press_chk("n_S5", 1, 0, 1);
        press_chk("d_S15", 0, 1, 3);
        press_chk("d_S25", 0, 1, 5);
        exp_q.push_back(1'b1);
        press_chk("d_S35_to_S0", 0, 1, 0);

        // Three dimes: exact price.
        press_chk("d_S10", 0, 1, 2);
        press_chk("d_S20", 0, 1, 4);
        exp_q.push_back(1'b0);
        press_chk("d_S30_to_S0", 0, 1, 0);

        // Nickel, dime, dime, nickel.
        press_chk("ndd_S5", 1, 0, 1);
        press_chk("ndd_S15", 0, 1, 3);
        press_chk("ndd_S25", 0, 1, 5);
        exp_q.push_back(1'b0);
        press_chk("n_S30_to_S0", 1, 0, 0);

        // Bouncing nickel then a short dime glitch.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.nb = ~i[0];
            @(negedge clk);
        end
        bus.nb = 1'b1;
        repeat (8) @(negedge clk);
        bus.nb = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_one_nickel", int'(dut.state_q), 1);
        bus.db = 1'b1;
        repeat (DIV_COUNT) @(negedge clk);
        bus.db = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_ignored", int'(dut.state_q), 1);
        press_chk("flush_S15", 0, 1, 3);
        press_chk("flush_S25", 0, 1, 5);
        exp_q.push_back(1'b1);
        press_chk("flush_S35_to_S0", 0, 1, 0);

        // Simultaneous coins, then a long hold.
        press_chk("both_dime_wins", 1, 1, 2);
        press(0, 1, 100);
        check("held_once", int'(dut.state_q), 4);
        exp_q.push_back(1'b0);
        press_chk("hold_S30_to_S0", 0, 1, 0);

        // Reset mid-credit, asynchronously between edges.
        press_chk("pre_rst_S5", 1, 0, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", int'(dut.state_q), 0);
        check("async_rst_s", int'(bus.s), 0);
        @(negedge clk);
        rst = 1'b1;
        press_chk("lost_S10", 0, 1, 2);
        press_chk("lost_S20", 0, 1, 4);
        exp_q.push_back(1'b0);
        press_chk("lost_S30_to_S0", 0, 1, 0);

        // Reset while the sell output is high.
        press_chk("pre2_S10", 0, 1, 2);
        press_chk("pre2_S20", 0, 1, 4);
        exp_q.push_back(1'b0);
        @(negedge clk);
        bus.db = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.s) found = 1'b1;
        end
        check("s_seen_before_rst", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_drops_s", int'(bus.s), 0);
        check("rst_drops_r", int'(bus.r), 0);
        bus.db = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_state", int'(dut.state_q), 0);
        check("post_rst_s", int'(bus.s), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_ctrl.md
Name: vending_machine_ctrl

Overview:
- Coin-accepting vending controller with two push-button coin inputs: nickel (5c) and dime (10c). Item price is 30c.
- Contains a free-running tick generator, two button debouncers with rising-edge detect, and a credit state machine.
- Asserts sell when 30c is reached, and sell plus return-change when credit overshoots to 35c.
- Top-level block between the board buttons/LEDs and the rest of the design. Single clock domain.

Parameters:
- DIV_COUNT, 100000, clk cycles per tick (1 kHz tick at 100 MHz); legal range >=2.
- DEB_SAMPLES, 4, consecutive equal tick samples required to change a debounced level; legal range >=2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-low; one clock, all flops cleared on rst=0.
- nb   input  1  raw nickel button, asynchronous, active-high, may bounce.
- db   input  1  raw dime button, asynchronous, active-high, may bounce.
- s    output 1  sell/dispense, registered.
- r    output 1  return 5c change, registered.

Behaviour:
- Reset (rst=0, async):
  - Tick counter = 0.
  - Synchronizers, debounce counters and debounced levels = 0.
  - FSM = S0.
  - s = 0, r = 0.
- Tick generator:
  - Counter runs 0..DIV_COUNT-1 and wraps.
  - tick = 1 for exactly one clk cycle when the counter equals DIV_COUNT-1.
  - No derived clocks; tick is used only as a clock enable.
- Debouncer (per button):
  - 2-flop synchronizer on clk.
  - On each tick, the synchronized sample is compared with the current debounced level:
    - If different, a match counter increments.
    - If equal, the match counter clears.
  - When the counter reaches DEB_SAMPLES, the debounced level takes the sample value and the counter clears.
  - Coin pulse = one-tick-wide (one clk, coincident with tick) rising edge of the debounced level.
  - A held button yields exactly one coin; glitches shorter than DEB_SAMPLES ticks yield none.
- FSM (advances only on tick):
  - States: S0, S5, S10, S15, S20, S25, S30, S35; encoded 0..7 as credit/5.
  - Transitions for S0..S25 (credit C):
    - Nickel pulse: C -> C+5.
    - Dime pulse: C -> C+10.
    - No coin: hold.
  - Dime in S25 -> S35.
  - S30 and S35 always return to S0 on the next tick; coins arriving during those states are ignored (lost).
  - Simultaneous nickel and dime pulses: dime taken, nickel discarded.
- Outputs (Moore, registered decode of state):
  - s = 1 in S30 and S35.
  - r = 1 in S35 only.
  - Each stays high for exactly one tick period (DIV_COUNT clks).
- Latency: a clean press becomes a coin pulse on the DEB_SAMPLES-th tick after the synchronized level changes. The state updates on that same tick edge, and s/r follow one clk later.
- Reset mid-operation: credit is lost, outputs drop immediately (asynchronous).

Decomposition:
- Package vending_pkg holds:
  - state enum (S0..S35, 3-bit);
  - PRICE_STATES = 6;
  - coin width constants.
- One natural sub-module: coin_debouncer (synchronizer + debounce + edge pulse), instantiated twice, parameterized by DEB_SAMPLES.
- Tick generator and FSM stay inline in vending_machine_ctrl.

Test Plan (DIV_COUNT=2, DEB_SAMPLES=2, hold each press >=8 clks, release >=8 clks):
- rst=0 then 1, no buttons -> s=0, r=0, state S0 indefinitely; rst=0 mid-credit forces s=r=0 and S0 without a clock edge.
- One nickel -> S5, s=0; three more dimes -> S15, S25, then S35 with s=1, r=1 for one tick, then S0.
- Three dimes -> S10, S20, S30: s=1, r=0 for exactly 2 clks, then S0 with no credit retained.
- Nickel, dime, dime, nickel -> S5, S15, S25, S30 -> s=1, r=0.
- Bounce: nb toggling every clk for 6 clks then stable high -> exactly one nickel counted; a 1-tick glitch on db -> no change.
- nb and db rising together from S0 -> S10 (dime wins); a button held 100 clks -> counted once.
